// File: rtl/int_to_float_pipe_if.sv
// int_to_float_pipe_if: operand-in / float-out valid-ready handshake bundle.
interface int_to_float_pipe_if #(
    parameter int bits_in  = 32,
    parameter int man_bits = 23,
    parameter int exp_bits = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic [bits_in-1:0]           in_data;
    logic                         in_signed;
    logic                         out_valid;
    logic                         out_ready;
    logic [exp_bits+man_bits:0]   out_data;
    modport master (output in_valid, in_data, in_signed, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, in_signed, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/int_to_float_pipe.sv
// int_to_float_pipe: 3-stage integer to IEEE-754-style float converter, round-to-nearest-even.
// Stages: sign/magnitude, leading-zero count, normalise/round; all stages stall together.
module clz #(
    parameter int w = 32
) (
    input  logic [w-1:0]         in_i,
    output logic [$clog2(w)-1:0] count_o,
    output logic                 valid_o
);
    localparam int cw = $clog2(w);
    always_comb begin
        count_o = '0;
        for (int i = 0; i < w; i++) if (in_i[i]) count_o = cw'(w - 1 - i);
    end
    assign valid_o = |in_i;
endmodule

module int_to_float_pipe #(
    parameter int bits_in  = 32,
    parameter int man_bits = 23,
    parameter int exp_bits = 8,
    parameter int bias     = 127
) (
    input logic                clk,
    input logic                rst_n,
    int_to_float_pipe_if.slave bus_io
);
    localparam int lzw = $clog2(bits_in);
    localparam int fw  = 1 + exp_bits + man_bits;
    // Selects the bits below the guard bit that feed the sticky OR.
    localparam logic [bits_in-1:0] st_mask = {bits_in{1'b1}} >> (man_bits + 2);

    if ((bits_in & (bits_in - 1)) != 0 || bits_in < 4 || bits_in < man_bits + 2) begin : g_bad_width
        $error("int_to_float_pipe: bits_in must be a power of two, >= 4 and >= man_bits+2");
    end
    if (bias + bits_in > 2 ** exp_bits - 2) begin : g_bad_exp
        $error("int_to_float_pipe: exponent range cannot hold bias+bits_in");
    end

    logic               v1_q, v2_q, v3_q, s1_q, s2_q, zero2_q;
    logic [bits_in-1:0] mag1_q, mag2_q;
    logic [lzw-1:0]     lz2_q;
    logic [fw-1:0]      out_q;
    logic               advance, s1_d, nz_d, up;
    logic [bits_in-1:0] mag1_d, norm;
    logic [lzw-1:0]     lz_d;
    logic [man_bits-1:0] frac;
    logic [man_bits:0]  sum;
    logic [exp_bits-1:0] e;
    logic [fw-1:0]      out_d;

    assign advance          = !v3_q || bus_io.out_ready;
    assign bus_io.in_ready  = advance;
    assign bus_io.out_valid = v3_q;
    assign bus_io.out_data  = out_q;

    assign s1_d   = bus_io.in_signed & bus_io.in_data[bits_in-1];
    assign mag1_d = s1_d ? ~bus_io.in_data + bits_in'(1) : bus_io.in_data;

    clz #(.w(bits_in)) u_clz (.in_i(mag1_q), .count_o(lz_d), .valid_o(nz_d));

    assign norm = mag2_q << lz2_q;
    assign frac = norm[bits_in-2 -: man_bits];
    assign up   = norm[bits_in-2-man_bits] & ((|(norm & st_mask)) | frac[0]);
    assign sum  = {1'b0, frac} + (man_bits + 1)'(up);
    // A carry out of the rounding add leaves the fraction bits already zero.
    assign e     = exp_bits'(bias + bits_in - 1) - exp_bits'(lz2_q) + exp_bits'(sum[man_bits]);
    assign out_d = zero2_q ? '0 : {s2_q, e, sum[man_bits-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            zero2_q <= 1'b0;
            mag1_q  <= '0;
            mag2_q  <= '0;
            lz2_q   <= '0;
            out_q   <= '0;
        end else if (advance) begin
            v1_q    <= bus_io.in_valid;
            s1_q    <= s1_d;
            mag1_q  <= mag1_d;
            v2_q    <= v1_q;
            s2_q    <= s1_q;
            mag2_q  <= mag1_q;
            lz2_q   <= lz_d;
            zero2_q <= !nz_d;
            v3_q    <= v2_q;
            out_q   <= out_d;
        end
    end
endmodule
